// File: rtl/vecadd_job_sequencer.sv
// vecadd_job_sequencer
// Feeds queued vector lengths to an ap_ctrl_hs VecAdd kernel one job at a time,
// taps the c output stream to count data beats, and retires each job once both
// the TLAST close token and ap_done have been observed. A job whose beat count
// differs from its n raises a sticky length error.
module vecadd_job_sequencer #(
  parameter int LEN_W  = 32,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_valid,
  output logic             job_ready,
  output logic             k_ap_start,
  output logic [LEN_W-1:0] k_n,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  input  logic             c_tvalid,
  input  logic             c_tready,
  input  logic             c_tlast,
  output logic             busy,
  output logic             done_valid,
  output logic [LEN_W-1:0] done_len,
  output logic             err_len,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RETIRE} state_t;

  state_t state, state_nxt;

  // job queue
  logic [LEN_W-1:0] q_mem [QDEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      q_cnt;
  logic             q_full, q_empty, push, pop;

  // per-job tracking
  logic [LEN_W-1:0] cnt;
  logic             saw_last, saw_done;
  logic             saw_last_nxt, saw_done_nxt;
  logic             track, data_beat, close_beat;

  assign q_full   = (q_cnt == (AW+1)'(QDEPTH));
  assign q_empty  = (q_cnt == '0);
  assign push     = job_valid && !q_full;
  assign pop      = (state == S_IDLE) && !q_empty;
  assign job_ready = !q_full;

  assign data_beat  = c_tvalid && c_tready && !c_tlast;
  assign close_beat = c_tvalid && c_tready && c_tlast;

  // Beats and ap_done are recorded from START onward, since a fast kernel may
  // begin streaming in the same cycle it acknowledges ap_start.
  assign track        = (state == S_START) || (state == S_RUN);
  assign saw_last_nxt = saw_last || (track && close_beat);
  assign saw_done_nxt = saw_done || (track && k_ap_done);

  assign k_ap_start = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign done_valid = (state == S_RETIRE);
  assign done_len   = done_valid ? cnt : '0;

  // queue storage write (data needs no reset; occupancy gates every read)
  always_ff @(posedge ap_clk) begin
    if (push) q_mem[wr_ptr] <= job_len;
  end

  // queue pointers and occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (AW+1)'(1);
        2'b01:   q_cnt <= q_cnt - (AW+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // next-state: retire as soon as close token and ap_done have both been seen,
  // counting events that land in the current cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!q_empty)                     state_nxt = S_START;
      S_START:  if (k_ap_ready)                   state_nxt = S_RUN;
      S_RUN:    if (saw_last_nxt && saw_done_nxt) state_nxt = S_RETIRE;
      S_RETIRE:                                   state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  // job datapath: load n on pop, count data beats (saturating), latch events
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      k_n      <= '0;
      cnt      <= '0;
      saw_last <= 1'b0;
      saw_done <= 1'b0;
    end else if (pop) begin
      k_n      <= q_mem[rd_ptr];
      cnt      <= '0;
      saw_last <= 1'b0;
      saw_done <= 1'b0;
    end else if (track) begin
      if (data_beat && (cnt != '1)) cnt <= cnt + LEN_W'(1);
      saw_last <= saw_last_nxt;
      saw_done <= saw_done_nxt;
    end
  end

  // retirement bookkeeping: wrapping job counter and sticky length error
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      jobs_done <= '0;
      err_len   <= 1'b0;
    end else if (state == S_RETIRE) begin
      jobs_done <= jobs_done + CNT_W'(1);
      if (cnt != k_n) err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vecadd_job_sequencer.sv
// Bench for vecadd_job_sequencer: emulates the kernel handshake and the c
// stream with randomized gaps, and predicts each retirement from a queue of
// accepted lengths plus the number of data beats actually streamed.
module tb_vecadd_job_sequencer;
  localparam int LEN_W = 32;
  localparam int QDEPTH = 4;
  localparam int CNT_W = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic             k_ap_start;
  logic [LEN_W-1:0] k_n;
  logic             k_ap_ready = 1'b0;
  logic             k_ap_done = 1'b0;
  logic             c_tvalid = 1'b0;
  logic             c_tready = 1'b0;
  logic             c_tlast = 1'b0;
  logic             busy;
  logic             done_valid;
  logic [LEN_W-1:0] done_len;
  logic             err_len;
  logic [CNT_W-1:0] jobs_done;

  int nvec = 0;
  int nerr = 0;
  int model_q[$];
  int model_jobs = 0;
  bit model_err = 1'b0;

  vecadd_job_sequencer #(.LEN_W(LEN_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .job_len(job_len), .job_valid(job_valid),
    .job_ready(job_ready), .k_ap_start(k_ap_start), .k_n(k_n), .k_ap_ready(k_ap_ready),
    .k_ap_done(k_ap_done), .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tlast(c_tlast),
    .busy(busy), .done_valid(done_valid), .done_len(done_len), .err_len(err_len),
    .jobs_done(jobs_done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  // Offer one job at the current negedge; the model says whether it must be taken.
  task automatic push_job(input int len, input bit exp_acc);
    job_valid = 1'b1;
    job_len   = LEN_W'(len);
    nvec++;
    if (job_ready !== exp_acc) begin
      nerr++;
      $display("FAIL push_ready len=%0d got=%b exp=%b", len, job_ready, exp_acc);
    end
    if (exp_acc) model_q.push_back(len);
    step();
  endtask

  // Act as the kernel for the job at the head of the model queue.
  // mode 0: ap_done after close, 1: ap_done the cycle before close,
  // 2: both in the same cycle. extra: data beats sent after the close token.
  task automatic serve(input int beats, input int mode, input int extra,
                       input bit stall, input int wait_max);
    int n_exp, sent, xleft, stall_left, dly, w, guard;
    bit closed, done_sent, first, got;
    n_exp = (model_q.size() > 0) ? model_q.pop_front() : -1;
    w = 0;
    while (k_ap_start !== 1'b1 && w < wait_max) begin
      step();
      w++;
    end
    nvec++;
    if (k_ap_start !== 1'b1) begin
      nerr++;
      $display("FAIL start_timeout got=%b exp=1 after %0d cycles", k_ap_start, w);
      return;
    end
    nvec++;
    if (k_n !== LEN_W'(n_exp)) begin
      nerr++;
      $display("FAIL k_n got=%0d exp=%0d", k_n, n_exp);
    end
    k_ap_ready = 1'b1;
    first = 1'b1; sent = 0; closed = 1'b0; done_sent = 1'b0; xleft = extra;
    stall_left = stall ? 10 : 0;
    dly = $urandom_range(0, 2);
    guard = 0;
    while (!(closed && done_sent && xleft == 0) && guard < 400) begin
      c_tvalid = 1'b0; c_tready = 1'b0; c_tlast = 1'b0; k_ap_done = 1'b0;
      if (stall_left > 0) begin
        c_tvalid = 1'b1;
        stall_left--;
      end else if (sent < beats) begin
        c_tvalid = ($urandom_range(0, 3) != 0);
        c_tready = ($urandom_range(0, 3) != 0);
        if (c_tvalid && c_tready) sent++;
        else c_tlast = 1'($urandom_range(0, 1));
      end else if (!closed) begin
        if (mode == 1 && !done_sent) begin
          k_ap_done = 1'b1;
          done_sent = 1'b1;
        end else begin
          c_tvalid = 1'b1; c_tready = 1'b1; c_tlast = 1'b1;
          closed = 1'b1;
          if (mode == 2) begin
            k_ap_done = 1'b1;
            done_sent = 1'b1;
          end
        end
      end else if (xleft > 0) begin
        c_tvalid = 1'b1; c_tready = 1'b1;
        xleft--;
      end else if (dly > 0) begin
        dly--;
      end else begin
        k_ap_done = 1'b1;
        done_sent = 1'b1;
      end
      step();
      guard++;
      if (first) begin
        k_ap_ready = 1'b0;
        first = 1'b0;
        nvec++;
        if (k_ap_start !== 1'b0) begin
          nerr++;
          $display("FAIL start_drop got=%b exp=0", k_ap_start);
        end
      end
      if (!(closed && done_sent && xleft == 0)) begin
        nvec++;
        if (done_valid !== 1'b0) begin
          nerr++;
          $display("FAIL early_done got=%b exp=0", done_valid);
        end
      end
    end
    c_tvalid = 1'b0; c_tready = 1'b0; c_tlast = 1'b0; k_ap_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (done_valid === 1'b1) got = 1'b1;
      else step();
    end
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL done_timeout got=%b exp=1", done_valid);
      return;
    end
    nvec++;
    if (done_len !== LEN_W'(beats + extra)) begin
      nerr++;
      $display("FAIL done_len got=%0d exp=%0d", done_len, beats + extra);
    end
    model_jobs = (model_jobs + 1) % (1 << CNT_W);
    if (beats + extra != n_exp) model_err = 1'b1;
    step();
    nvec++;
    if (done_valid !== 1'b0) begin
      nerr++;
      $display("FAIL done_pulse got=%b exp=0", done_valid);
    end
    nvec++;
    if (jobs_done !== CNT_W'(model_jobs)) begin
      nerr++;
      $display("FAIL jobs_done got=%0d exp=%0d", jobs_done, model_jobs);
    end
    nvec++;
    if (err_len !== model_err) begin
      nerr++;
      $display("FAIL err_len got=%b exp=%b", err_len, model_err);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    nvec++;
    if ({k_ap_start, busy, done_valid, err_len} !== 4'b0 || k_n !== '0 ||
        done_len !== '0 || jobs_done !== '0) begin
      nerr++;
      $display("FAIL %s got start=%b busy=%b dv=%b err=%b k_n=%0d len=%0d jobs=%0d exp all zero",
               tag, k_ap_start, busy, done_valid, err_len, k_n, done_len, jobs_done);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_state");
    step();
    ap_rst_n = 1'b1;
    step();
    nvec++;
    if (job_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_job_ready got=%b exp=1", job_ready);
    end
  endtask

  task automatic test_single();
    push_job(5, 1'b1);
    job_valid = 1'b0;
    nvec++;
    if (k_ap_start !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL start_latency_early got start=%b busy=%b exp 0 0", k_ap_start, busy);
    end
    step();
    nvec++;
    if (k_ap_start !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL start_latency got start=%b busy=%b exp 1 1", k_ap_start, busy);
    end
    serve(5, 0, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int lens[5] = '{5, 3, 0, 7, 2};
    // first push is popped at once, the next four fill the queue
    foreach (lens[i]) push_job(lens[i], 1'b1);
    push_job(9, 1'b0);
    job_valid = 1'b0;
    serve(5, $urandom_range(0, 2), 0, 1'b0, 5);
    for (int i = 1; i < 5; i++) serve(lens[i], $urandom_range(0, 2), 0, 1'b0, 1);
    step(); step(); step();
    nvec++;
    if (busy !== 1'b0 || k_ap_start !== 1'b0) begin
      nerr++;
      $display("FAIL no_phantom_job got busy=%b start=%b exp 0 0", busy, k_ap_start);
    end
  endtask

  task automatic test_done_order();
    push_job(4, 1'b1); job_valid = 1'b0;
    serve(4, 1, 0, 1'b0, 5);
    push_job(6, 1'b1); job_valid = 1'b0;
    serve(6, 2, 0, 1'b0, 5);
    push_job(0, 1'b1); job_valid = 1'b0;
    serve(0, 1, 0, 1'b0, 5);
  endtask

  task automatic test_len_error();
    push_job(5, 1'b1); job_valid = 1'b0;
    serve(4, 0, 0, 1'b0, 5);
    push_job(3, 1'b1); job_valid = 1'b0;
    serve(3, 0, 0, 1'b0, 5);
    push_job(2, 1'b1); job_valid = 1'b0;
    serve(2, 0, 1, 1'b0, 5);
  endtask

  task automatic test_reset_mid_job();
    int w;
    push_job(5, 1'b1); job_valid = 1'b0;
    w = 0;
    while (k_ap_start !== 1'b1 && w < 5) begin step(); w++; end
    void'(model_q.pop_front());
    k_ap_ready = 1'b1; c_tvalid = 1'b1; c_tready = 1'b1;
    step();
    k_ap_ready = 1'b0;
    step();
    c_tvalid = 1'b0; c_tready = 1'b0;
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL mid_job_busy got=%b exp=1", busy);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_job");
    model_q.delete();
    model_jobs = 0;
    model_err = 1'b0;
    step();
    ap_rst_n = 1'b1;
    step();
    nvec++;
    if (done_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL after_reset got dv=%b busy=%b exp 0 0", done_valid, busy);
    end
    push_job(6, 1'b1); job_valid = 1'b0;
    serve(6, 0, 0, 1'b0, 5);
  endtask

  task automatic test_stall();
    push_job(4, 1'b1); job_valid = 1'b0;
    serve(4, 0, 0, 1'b1, 5);
    push_job(3, 1'b1); job_valid = 1'b0;
    serve(3, 2, 0, 1'b1, 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_done_order();
    test_len_error();
    test_reset_mid_job();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
